// File: rtl/read_response_handler.sv
// -----------------------------------------------------------------------------
// read_response_handler
//
// Consumes channel-0 read responses coming back from the memory port and closes
// the loop opened by the read engine:
//   * control-tagged lines are decoded into a command/acknowledge stream
//   * run-tagged lines are counted and checksummed until the run's expected
//     line count has arrived
//   * anything unexpected is tallied in saturating error counters
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   afu_state           current AFU state (RUN/CTRL keep the handler alive)
//   rsp_valid           read response valid, at most one per cycle
//   rsp_mdata           response tag
//   rsp_data            512-bit response cache line
//   ctrl_resp_*         command stream: valid, ack, code, rd_addr, num_cls
//   run_complete        one-cycle pulse when the last expected run line lands
//   run_active          high while a run is in progress
//   run_lines           run lines accepted in the current run
//   run_checksum        mod 2^64 sum of the selected 64-bit word of each line
//   stray_cnt           run lines received outside a run (saturating)
//   bad_tag_cnt         responses carrying an unknown tag (saturating)
// -----------------------------------------------------------------------------
module read_response_handler #(
   parameter int                     CHECKSUM_WORD     = 0,
   parameter int                     INCLUSIVE_RANGE   = 1,
   parameter int                     MDATA_W           = 16,
   parameter int                     ADDR_W            = 42,
   parameter int                     AFU_STATE_W       = 3,
   parameter logic [MDATA_W-1:0]     READ_CTRL_MDATA   = 16'h00C1,
   parameter logic [MDATA_W-1:0]     READ_RUN_MDATA    = 16'h00A5,
   parameter logic [31:0]            CONTROL_START_RUN = 32'd1,
   parameter logic [AFU_STATE_W-1:0] AFU_CTRL          = 3'd1,
   parameter logic [AFU_STATE_W-1:0] AFU_RUN           = 3'd2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [AFU_STATE_W-1:0] afu_state,
   input  logic                   rsp_valid,
   input  logic [MDATA_W-1:0]     rsp_mdata,
   input  logic [511:0]           rsp_data,
   output logic                   ctrl_resp_valid,
   output logic                   ctrl_resp_ack,
   output logic [31:0]            ctrl_resp_code,
   output logic [ADDR_W-1:0]      ctrl_resp_rd_addr,
   output logic [31:0]            ctrl_resp_num_cls,
   output logic                   run_complete,
   output logic                   run_active,
   output logic [31:0]            run_lines,
   output logic [63:0]            run_checksum,
   output logic [15:0]            stray_cnt,
   output logic [15:0]            bad_tag_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0]  CK_IDX  = 3'(CHECKSUM_WORD);
   localparam logic [31:0] RANGE_ADJ = 32'(INCLUSIVE_RANGE);

   // Split the line into its eight 64-bit words for checksum selection.
   logic [63:0] words [8];
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_word
         assign words[gi] = rsp_data[gi*64 +: 64];
      end
   endgenerate

   // Control line fields.
   logic [31:0]       line_code;
   logic [31:0]       line_num;
   logic [ADDR_W-1:0] line_addr;
   logic [31:0]       line_seq;
   assign line_code = rsp_data[31:0];
   assign line_num  = rsp_data[63:32];
   assign line_addr = rsp_data[64 +: ADDR_W];
   assign line_seq  = rsp_data[159:128];

   // Most of the line is payload this block never looks at.
   logic unused_bits;
   assign unused_bits = ^rsp_data;

   logic [1:0]        state_reg, state_next;
   logic [31:0]       last_seq_reg, last_seq_next;
   logic [31:0]       expected_reg, expected_next;
   logic              valid_reg, valid_next;
   logic              ack_reg, ack_next;
   logic [31:0]       code_reg, code_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [31:0]       num_reg, num_next;
   logic              complete_reg, complete_next;
   logic [31:0]       lines_reg, lines_next;
   logic [63:0]       sum_reg, sum_next;
   logic [15:0]       stray_reg, stray_next;
   logic [15:0]       bad_reg, bad_next;

   logic is_ctrl, is_run, is_bad, accept, start, afu_ok;
   logic [31:0] lines_inc;

   assign is_ctrl   = rsp_valid && (rsp_mdata == READ_CTRL_MDATA);
   assign is_run    = rsp_valid && (rsp_mdata == READ_RUN_MDATA);
   assign is_bad    = rsp_valid && !is_ctrl && !is_run;
   // A repeated seq or a zero code is a stale poll result: ack only.
   assign accept    = is_ctrl && (line_seq != last_seq_reg) && (line_code != 32'd0);
   assign afu_ok    = (afu_state == AFU_RUN) || (afu_state == AFU_CTRL);
   assign start     = accept && (line_code == CONTROL_START_RUN) && afu_ok;
   assign lines_inc = lines_reg + 32'd1;

   always_comb begin
      state_next    = state_reg;
      last_seq_next = last_seq_reg;
      expected_next = expected_reg;
      valid_next    = accept;
      ack_next      = is_ctrl;
      code_next     = code_reg;
      addr_next     = addr_reg;
      num_next      = num_reg;
      complete_next = 1'b0;
      lines_next    = lines_reg;
      sum_next      = sum_reg;
      stray_next    = stray_reg;
      bad_next      = bad_reg;

      if (accept) begin
         code_next     = line_code;
         addr_next     = line_addr;
         num_next      = line_num;
         last_seq_next = line_seq;
      end

      if (is_bad && bad_reg != 16'hFFFF)
         bad_next = bad_reg + 16'd1;

      case (state_reg)
         ST_RUN: begin
            if (expected_reg == 32'd0) begin
               // Expected count wrapped to zero: finish straight away; any
               // run line landing now is already excess.
               state_next    = ST_DONE;
               complete_next = 1'b1;
               if (is_run && stray_reg != 16'hFFFF)
                  stray_next = stray_reg + 16'd1;
            end else if (is_run) begin
               lines_next = lines_inc;
               sum_next   = sum_reg + words[CK_IDX];
               if (lines_inc == expected_reg) begin
                  state_next    = ST_DONE;
                  complete_next = 1'b1;
               end
            end
         end
         default: begin
            if (is_run && stray_reg != 16'hFFFF)
               stray_next = stray_reg + 16'd1;
         end
      endcase

      // A start accepted in any state (re)opens the run from scratch.
      if (start) begin
         state_next    = ST_RUN;
         lines_next    = 32'd0;
         sum_next      = 64'd0;
         expected_next = line_num + RANGE_ADJ;
      end

      // Leaving the AFU run/control states abandons the run; counters hold.
      if (!afu_ok) begin
         state_next    = ST_IDLE;
         complete_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         last_seq_reg <= '0;
         expected_reg <= '0;
         valid_reg    <= 1'b0;
         ack_reg      <= 1'b0;
         code_reg     <= '0;
         addr_reg     <= '0;
         num_reg      <= '0;
         complete_reg <= 1'b0;
         lines_reg    <= '0;
         sum_reg      <= '0;
         stray_reg    <= '0;
         bad_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         last_seq_reg <= last_seq_next;
         expected_reg <= expected_next;
         valid_reg    <= valid_next;
         ack_reg      <= ack_next;
         code_reg     <= code_next;
         addr_reg     <= addr_next;
         num_reg      <= num_next;
         complete_reg <= complete_next;
         lines_reg    <= lines_next;
         sum_reg      <= sum_next;
         stray_reg    <= stray_next;
         bad_reg      <= bad_next;
      end
   end

   assign ctrl_resp_valid   = valid_reg;
   assign ctrl_resp_ack     = ack_reg;
   assign ctrl_resp_code    = code_reg;
   assign ctrl_resp_rd_addr = addr_reg;
   assign ctrl_resp_num_cls = num_reg;
   assign run_complete      = complete_reg;
   assign run_active        = (state_reg == ST_RUN);
   assign run_lines         = lines_reg;
   assign run_checksum      = sum_reg;
   assign stray_cnt         = stray_reg;
   assign bad_tag_cnt       = bad_reg;

endmodule

// File: tb/tb_read_response_handler.sv
// -----------------------------------------------------------------------------
// tb_read_response_handler
//
// Drives directed scenarios followed by random response traffic into
// read_response_handler and compares every output, every cycle, against a
// transaction-level reference model of the run/command behaviour.
// -----------------------------------------------------------------------------
module tb_read_response_handler;

   localparam logic [15:0] CTRL_TAG  = 16'h00C1;
   localparam logic [15:0] RUN_TAG   = 16'h00A5;
   localparam logic [31:0] START_RUN = 32'd1;
   localparam logic [2:0]  AFU_CTRL  = 3'd1;
   localparam logic [2:0]  AFU_RUN   = 3'd2;
   localparam int          CK_WORD   = 0;
   localparam int          INC_RANGE = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   afu_state;
   logic         rsp_valid;
   logic [15:0]  rsp_mdata;
   logic [511:0] rsp_data;
   logic         ctrl_resp_valid;
   logic         ctrl_resp_ack;
   logic [31:0]  ctrl_resp_code;
   logic [41:0]  ctrl_resp_rd_addr;
   logic [31:0]  ctrl_resp_num_cls;
   logic         run_complete;
   logic         run_active;
   logic [31:0]  run_lines;
   logic [63:0]  run_checksum;
   logic [15:0]  stray_cnt;
   logic [15:0]  bad_tag_cnt;

   always #5 clk = ~clk;

   read_response_handler #(
      .CHECKSUM_WORD(CK_WORD), .INCLUSIVE_RANGE(INC_RANGE),
      .MDATA_W(16), .ADDR_W(42), .AFU_STATE_W(3),
      .READ_CTRL_MDATA(CTRL_TAG), .READ_RUN_MDATA(RUN_TAG),
      .CONTROL_START_RUN(START_RUN), .AFU_CTRL(AFU_CTRL), .AFU_RUN(AFU_RUN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .afu_state(afu_state),
      .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
      .ctrl_resp_valid(ctrl_resp_valid), .ctrl_resp_ack(ctrl_resp_ack),
      .ctrl_resp_code(ctrl_resp_code), .ctrl_resp_rd_addr(ctrl_resp_rd_addr),
      .ctrl_resp_num_cls(ctrl_resp_num_cls), .run_complete(run_complete),
      .run_active(run_active), .run_lines(run_lines), .run_checksum(run_checksum),
      .stray_cnt(stray_cnt), .bad_tag_cnt(bad_tag_cnt)
   );

   int total = 0;
   int bad = 0;
   int txn = 0;

   // Reference model: a run is "open" with a number of lines still owed.
   bit              m_open;
   longint unsigned m_owed;
   logic [31:0]     m_last_seq;
   logic            e_valid, e_ack, e_complete;
   logic [31:0]     e_code, e_num, e_lines;
   logic [41:0]     e_addr;
   logic [63:0]     e_sum;
   int              e_stray, e_bad;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (txn %0d)", tag, got, exp, txn);
      end
   endtask

   task automatic check_all();
      check_eq("valid",    ctrl_resp_valid,   e_valid);
      check_eq("ack",      ctrl_resp_ack,     e_ack);
      check_eq("code",     ctrl_resp_code,    e_code);
      check_eq("rd_addr",  ctrl_resp_rd_addr, e_addr);
      check_eq("num_cls",  ctrl_resp_num_cls, e_num);
      check_eq("complete", run_complete,      e_complete);
      check_eq("active",   run_active,        m_open);
      check_eq("lines",    run_lines,         e_lines);
      check_eq("checksum", run_checksum,      e_sum);
      check_eq("stray",    stray_cnt,         16'(e_stray));
      check_eq("bad_tag",  bad_tag_cnt,       16'(e_bad));
   endtask

   task automatic model_reset();
      m_open = 0; m_owed = 0; m_last_seq = 0;
      e_valid = 0; e_ack = 0; e_complete = 0;
      e_code = 0; e_num = 0; e_lines = 0; e_addr = 0; e_sum = 0;
      e_stray = 0; e_bad = 0;
   endtask

   // Apply the behavioural rules to the response presented at this edge.
   task automatic model_step();
      bit ctrl, run, afu_ok, start;
      logic [31:0] code, num, seq;
      ctrl   = rsp_valid && rsp_mdata == CTRL_TAG;
      run    = rsp_valid && rsp_mdata == RUN_TAG;
      afu_ok = (afu_state == AFU_RUN) || (afu_state == AFU_CTRL);
      code = rsp_data[31:0]; num = rsp_data[63:32]; seq = rsp_data[159:128];
      e_ack = ctrl;
      e_valid = ctrl && seq != m_last_seq && code != 0;
      e_complete = 0;
      start = 0;
      if (e_valid) begin
         e_code = code; e_num = num; e_addr = rsp_data[105:64]; m_last_seq = seq;
         start = (code == START_RUN) && afu_ok;
      end
      if (rsp_valid && !ctrl && !run) e_bad = (e_bad < 65535) ? e_bad + 1 : e_bad;
      if (m_open && m_owed == 0) begin
         e_complete = 1; m_open = 0;
         if (run) e_stray = (e_stray < 65535) ? e_stray + 1 : e_stray;
      end else if (m_open && run) begin
         e_lines = e_lines + 1;
         e_sum = e_sum + rsp_data[CK_WORD*64 +: 64];
         m_owed = m_owed - 1;
         if (m_owed == 0) begin e_complete = 1; m_open = 0; end
      end else if (run) begin
         e_stray = (e_stray < 65535) ? e_stray + 1 : e_stray;
      end
      if (start) begin
         m_open = 1; e_lines = 0; e_sum = 0;
         m_owed = longint'((num + 64'(INC_RANGE)) % 64'h1_0000_0000);
      end
      if (!afu_ok) begin m_open = 0; e_complete = 0; end
   endtask

   task automatic drive(input logic v, input logic [15:0] tag, input logic [511:0] data, input string name);
      @(negedge clk);
      rsp_valid = v; rsp_mdata = tag; rsp_data = data;
      @(posedge clk);
      model_step();
      #1;
      txn++;
      check_all();
      $display("txn %0d %s: ack=%0d valid=%0d active=%0d lines=%0d sum=%0h stray=%0d bad_tag=%0d",
               txn, name, ctrl_resp_ack, ctrl_resp_valid, run_active, run_lines,
               run_checksum, stray_cnt, bad_tag_cnt);
      rsp_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 model_reset();
      txn++;
      check_all();
      $display("txn %0d reset: active=%0d lines=%0d", txn, run_active, run_lines);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [511:0] ctrl_line(input logic [31:0] code, input logic [31:0] num,
                                              input logic [63:0] addr, input logic [31:0] seq);
      logic [511:0] l;
      l = rand_line();
      l[31:0] = code; l[63:32] = num; l[127:64] = addr; l[159:128] = seq;
      return l;
   endfunction

   function automatic logic [511:0] run_line(input logic [63:0] w0);
      logic [511:0] l;
      l = rand_line();
      l[63:0] = w0;
      return l;
   endfunction

   initial begin
      logic [511:0] line;
      logic [15:0]  tag;
      int           k;
      afu_state = AFU_RUN; rsp_valid = 1'b0; rsp_mdata = '0; rsp_data = '0;
      model_reset();
      #1 check_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Command accept and start of a 4-line run.
      drive(1, CTRL_TAG, ctrl_line(START_RUN, 32'd3, 64'h1000, 32'd1), "start");
      check_eq("plan_valid", ctrl_resp_valid, 1'b1);
      check_eq("plan_addr", ctrl_resp_rd_addr, 42'h1000);
      check_eq("plan_active", run_active, 1'b1);
      // Duplicate seq: ack without valid.
      drive(1, CTRL_TAG, ctrl_line(START_RUN, 32'd3, 64'h1000, 32'd1), "dup_seq");
      drive(1, CTRL_TAG, ctrl_line(START_RUN, 32'd3, 64'h1000, 32'd1), "dup_seq");
      check_eq("plan_dup_valid", ctrl_resp_valid, 1'b0);
      for (int i = 1; i <= 4; i++) drive(1, RUN_TAG, run_line(64'(i)), "run_line");
      check_eq("plan_lines", run_lines, 32'd4);
      check_eq("plan_sum", run_checksum, 64'd10);
      check_eq("plan_complete", run_complete, 1'b1);
      drive(1, RUN_TAG, run_line(64'd5), "excess");
      check_eq("plan_excess", stray_cnt, 16'd1);
      // Error counting while idle.
      afu_state = 3'd0;
      drive(0, 16'h0, '0, "to_idle");
      afu_state = AFU_RUN;
      drive(1, RUN_TAG, run_line(64'd9), "idle_run");
      drive(1, 16'hBEEF, rand_line(), "bad_tag");
      check_eq("plan_bad", bad_tag_cnt, 16'd1);
      // Reset mid-run, then the same seq is accepted again.
      do_reset();
      drive(1, CTRL_TAG, ctrl_line(START_RUN, 32'd3, 64'h2000, 32'd1), "start");
      drive(1, RUN_TAG, run_line(64'd7), "run_line");
      drive(1, RUN_TAG, run_line(64'd8), "run_line");
      do_reset();
      drive(1, CTRL_TAG, ctrl_line(START_RUN, 32'd3, 64'h1000, 32'd1), "restart");
      check_eq("plan_reaccept", ctrl_resp_valid, 1'b1);
      // Expected count wraps to zero.
      drive(1, CTRL_TAG, ctrl_line(START_RUN, 32'hFFFF_FFFF, 64'h3000, 32'd2), "wrap_start");
      drive(0, 16'h0, '0, "wrap_idle");
      check_eq("plan_wrap_done", run_complete, 1'b1);
      check_eq("plan_wrap_lines", run_lines, 32'd0);

      // Random traffic.
      for (int n = 0; n < 500; n++) begin
         k = $urandom_range(0, 99);
         afu_state = (k < 3) ? 3'd0 : (k < 8) ? AFU_CTRL : AFU_RUN;
         k = $urandom_range(0, 99);
         if (k < 2) begin
            do_reset();
         end else if (k < 22) begin
            line = ctrl_line((($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : START_RUN),
                             (($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 6))),
                             {$urandom, $urandom}, 32'($urandom_range(0, 3)));
            drive(1, CTRL_TAG, line, "rnd_ctrl");
         end else if (k < 72) begin
            drive(1, RUN_TAG, rand_line(), "rnd_run");
         end else if (k < 80) begin
            tag = 16'($urandom);
            if (tag == CTRL_TAG || tag == RUN_TAG) tag = 16'hBEEF;
            drive(1, tag, rand_line(), "rnd_bad");
         end else begin
            drive(0, 16'($urandom), rand_line(), "rnd_idle");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/read_response_handler.md
# read_response_handler

Consumes CCI-P channel-0 read responses and completes the loop opened by the read engine. Lines tagged `READ_CTRL_MDATA` are decoded into the `ctrl_resp_if` command/acknowledge stream. Lines tagged `READ_RUN_MDATA` are counted and checksummed until the run's expected line count is reached. It sits between the MPF c0 response port and the AFU control FSM/read engine.

## Interface
Parameters:
- `CHECKSUM_WORD`, default 0: index (0–7) of the 64-bit word of each run line added into the checksum.
- `INCLUSIVE_RANGE`, default 1: 1 means expected run lines = `num_cls + 1`; 0 means `num_cls`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `afu_state`  in  `e_afu_state`  current AFU state.
- `rsp_valid`  in  1  c0 read response valid; at most one per cycle.
- `rsp_mdata`  in  `t_cci_mdata`  response tag.
- `rsp_data`  in  `t_cci_clData` (512)  response cache line.
- `ctrl_resp`  out  `ctrl_resp_if`  drives `valid`, `ack`, `code` (`t_uint32`), `rd_addr` (`t_cci_clAddr`), `num_cls` (`t_uint32`).
- `run_complete`  out  1  one-cycle pulse when the last expected run line arrives.
- `run_active`  out  1  high while in RUN.
- `run_lines`  out  `t_uint32`  run lines accepted in the current run.
- `run_checksum`  out  64  modular sum of the selected words.
- `stray_cnt`  out  16  run-tagged lines received outside RUN, plus excess lines.
- `bad_tag_cnt`  out  16  responses with any other mdata.

## Operation
- Control line layout:
  - `[31:0]` code.
  - `[63:32]` num_cls.
  - `[127:64]` rd_addr (low `$bits(t_cci_clAddr)` bits used).
  - `[159:128]` seq.
- Control response handling:
  - Every control-tagged response pulses `ctrl_resp.ack` for one cycle. This releases the read engine's poll wait.
  - `ctrl_resp.valid` pulses with the same `ack` only if `seq != last_seq` and `code != 0`. `last_seq` then updates.
  - A repeated seq, or code 0, produces ack only. This stops stale poll results from re-issuing a command.
  - `code`, `rd_addr` and `num_cls` are registered and held from the last valid command.
- FSM states are IDLE, RUN and DONE:
  - IDLE → RUN on an accepted command with `code == CONTROL_START_RUN`. On this transition, clear `run_lines` and `run_checksum`, and load `expected = num_cls + INCLUSIVE_RANGE` (32-bit, wraps).
  - RUN: each run-tagged response increments `run_lines` and adds the selected word to `run_checksum` (mod 2^64).
  - RUN → DONE when the incremented count equals `expected`; `run_complete` pulses in the same cycle the count update is visible. If `expected == 0`, go to DONE on the cycle after entry, with a `run_complete` pulse.
  - DONE: run outputs hold. Further run-tagged responses increment `stray_cnt` only.
  - DONE → RUN on another accepted `CONTROL_START_RUN`, with the same clearing as IDLE → RUN.
  - Any state → IDLE when `afu_state` is neither `AFU_RUN` nor `AFU_CTRL`. Counters hold.
- Run-tagged responses in IDLE increment `stray_cnt`.
- Other mdata values increment `bad_tag_cnt`.
- `stray_cnt` and `bad_tag_cnt` saturate at 0xFFFF and clear only on reset.
- A control-tagged response in RUN is still decoded. A START_RUN accepted in RUN restarts the run: counters are cleared and the in-progress response count is discarded.

## Timing
- All outputs are registered. Latency is 1 cycle from `rsp_valid` to `ack`, `valid`, counter update and `run_complete`.
- Back-to-back responses are accepted every cycle with no stall and no backpressure.
- Reset (asynchronous assert, synchronous-safe deassert), applied at any time:
  - FSM goes to IDLE.
  - All outputs go to 0, including `ctrl_resp.valid`, `ack` and all fields.
  - `last_seq` resets to 0, so a first command must use seq ≠ 0.
- Reset mid-run drops the run with no `run_complete`.

## Test plan
- Control command: control line with code=`CONTROL_START_RUN`, num_cls=3, rd_addr=0x1000, seq=1 → next cycle `ack`=1 and `valid`=1 with the fields as sent; `run_active` rises; expected=4.
- Duplicate seq: the same line repeated twice, seq=1 → `ack` pulses twice, `valid` never pulses, state unchanged.
- Run completion: after the start above, 4 back-to-back run lines with word0 = 1, 2, 3, 4 → `run_lines`=4, `run_checksum`=10, single `run_complete` pulse 1 cycle after the 4th; a 5th line → `stray_cnt`=1, `run_lines` stays 4.
- Error counting: a run line while IDLE, plus a response with mdata=0xBEEF → `stray_cnt`=1, `bad_tag_cnt`=1, no other output change.
- Reset mid-run: `rst_n` low after 2 of 4 lines → all outputs 0 immediately; after release, seq=1 start is accepted again.
- Wrap/zero: num_cls=0xFFFFFFFF with INCLUSIVE_RANGE=1 → expected=0 → `run_complete` the cycle after entry, `run_lines`=0.
